// File: rtl/btb_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : btb_predictor_if
// Description : Fetch lookup, EX update and statistics bundle for the BTB.
// Revision    : 1.0 - initial release
// ============================================================================
interface btb_predictor_if #(
    parameter int XLEN               = 32,
    parameter int PERF_COUNTER_WIDTH = 32
);
    logic                          if_valid;
    logic [XLEN-1:0]               if_pc;
    logic                          pred_hit;
    logic                          pred_taken;
    logic [XLEN-1:0]               pred_target;
    logic [1:0]                    pred_state;
    logic                          upd_en;
    logic [XLEN-1:0]               upd_pc;
    logic                          upd_taken;
    logic [XLEN-1:0]               upd_target;
    logic                          upd_is_jump;
    logic                          upd_mispredict;
    logic                          flush_all;
    logic [PERF_COUNTER_WIDTH-1:0] hit_count;
    logic [PERF_COUNTER_WIDTH-1:0] mispredict_count;

    modport master (
        output if_valid, if_pc, upd_en, upd_pc, upd_taken, upd_target,
               upd_is_jump, upd_mispredict, flush_all,
        input  pred_hit, pred_taken, pred_target, pred_state,
               hit_count, mispredict_count
    );

    modport slave (
        input  if_valid, if_pc, upd_en, upd_pc, upd_taken, upd_target,
               upd_is_jump, upd_mispredict, flush_all,
        output pred_hit, pred_taken, pred_target, pred_state,
               hit_count, mispredict_count
    );
endinterface
`default_nettype wire

// File: rtl/btb_predictor.sv
`default_nettype none
// ============================================================================
// Module      : btb_predictor
// Description : Direct-mapped BTB with 2-bit saturating direction counters.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_predictor #(
    parameter int XLEN               = 32,
    parameter int BTB_SIZE           = 64,
    parameter int BTB_INDEX_WIDTH    = $clog2(BTB_SIZE),
    parameter int BTB_TAG_WIDTH      = XLEN - BTB_INDEX_WIDTH - 2,
    parameter int PERF_COUNTER_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    btb_predictor_if.slave  bus
);
    localparam logic [1:0] C_STRONG_NT = 2'b00;
    localparam logic [1:0] C_WEAK_NT   = 2'b01;
    localparam logic [1:0] C_WEAK_T    = 2'b10;
    localparam logic [1:0] C_STRONG_T  = 2'b11;
    localparam logic [XLEN-1:0]               C_PC_STEP = XLEN'(4);
    localparam logic [PERF_COUNTER_WIDTH-1:0] C_CNT_ONE = PERF_COUNTER_WIDTH'(1);

    logic [BTB_SIZE-1:0]           r_valid;
    logic [1:0]                    r_state  [BTB_SIZE];
    logic [BTB_TAG_WIDTH-1:0]      r_tag    [BTB_SIZE];
    logic [XLEN-1:0]               r_target [BTB_SIZE];
    logic [PERF_COUNTER_WIDTH-1:0] r_hit_count;
    logic [PERF_COUNTER_WIDTH-1:0] r_mis_count;

    logic [BTB_INDEX_WIDTH-1:0] w_lk_idx;
    logic [BTB_TAG_WIDTH-1:0]   w_lk_tag;
    logic                       w_lk_hit;
    logic                       w_lk_taken;
    logic [BTB_INDEX_WIDTH-1:0] w_up_idx;
    logic [BTB_TAG_WIDTH-1:0]   w_up_tag;
    logic                       w_up_hit;
    logic                       w_up_act;
    logic                       w_wr_target;
    logic                       w_alloc;

    // PC bits [1:0] never participate in indexing or tagging.
    logic w_unused;
    assign w_unused = &{1'b0, bus.if_pc[1:0], bus.upd_pc[1:0]};

    assign w_lk_idx   = bus.if_pc[BTB_INDEX_WIDTH+1:2];
    assign w_lk_tag   = bus.if_pc[XLEN-1:BTB_INDEX_WIDTH+2];
    assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_lk_taken = w_lk_hit && r_state[w_lk_idx][1];

    assign bus.pred_hit    = w_lk_hit;
    assign bus.pred_taken  = w_lk_taken;
    assign bus.pred_target = w_lk_taken ? r_target[w_lk_idx] : (bus.if_pc + C_PC_STEP);
    assign bus.pred_state  = w_lk_hit ? r_state[w_lk_idx] : C_WEAK_NT;

    assign w_up_idx    = bus.upd_pc[BTB_INDEX_WIDTH+1:2];
    assign w_up_tag    = bus.upd_pc[XLEN-1:BTB_INDEX_WIDTH+2];
    assign w_up_hit    = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    // A flush in the same cycle suppresses the whole update.
    assign w_up_act    = bus.upd_en && !bus.flush_all;
    assign w_alloc     = w_up_act && !w_up_hit && bus.upd_taken;
    assign w_wr_target = w_alloc || (w_up_act && w_up_hit && (bus.upd_is_jump || bus.upd_taken));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < BTB_SIZE; i++) begin
                r_state[i] <= C_WEAK_NT;
            end
        end else if (bus.flush_all) begin
            r_valid <= '0;
        end else if (bus.upd_en) begin
            if (w_up_hit) begin
                if (bus.upd_is_jump) begin
                    r_state[w_up_idx] <= C_STRONG_T;
                end else if (bus.upd_taken) begin
                    if (r_state[w_up_idx] != C_STRONG_T) begin
                        r_state[w_up_idx] <= r_state[w_up_idx] + 2'd1;
                    end
                end else if (r_state[w_up_idx] != C_STRONG_NT) begin
                    r_state[w_up_idx] <= r_state[w_up_idx] - 2'd1;
                end
            end else if (bus.upd_taken) begin
                r_valid[w_up_idx] <= 1'b1;
                r_state[w_up_idx] <= bus.upd_is_jump ? C_STRONG_T : C_WEAK_T;
            end
        end
    end

    // Tags and targets carry no reset; they are unreachable while invalid.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_target) begin
            r_target[w_up_idx] <= bus.upd_target;
        end
        if (!rst && w_alloc) begin
            r_tag[w_up_idx] <= w_up_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_count <= '0;
            r_mis_count <= '0;
        end else begin
            if (bus.if_valid && w_lk_hit && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + C_CNT_ONE;
            end
            if (bus.upd_en && bus.upd_mispredict && (r_mis_count != '1)) begin
                r_mis_count <= r_mis_count + C_CNT_ONE;
            end
        end
    end

    assign bus.hit_count        = r_hit_count;
    assign bus.mispredict_count = r_mis_count;
endmodule
`default_nettype wire

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
Direct-mapped Branch Target Buffer with 2-bit saturating direction counters. It sits alongside the IF stage and supplies a next-PC prediction for the current fetch PC. It is trained by branches and jumps resolved in EX. Entry count, tag width and counter encoding (STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11) come from the core package.

Parameters:
XLEN, 32, datapath and PC width
BTB_SIZE, 64, number of entries (power of two)
BTB_INDEX_WIDTH, $clog2(BTB_SIZE), index bits, taken from PC[INDEX_W+1:2]
BTB_TAG_WIDTH, XLEN-BTB_INDEX_WIDTH-2, tag bits, taken from PC[XLEN-1:INDEX_W+2]
PERF_COUNTER_WIDTH, 32, width of the statistics counters

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
if_valid  in  1  fetch PC is valid this cycle; qualifies statistics only
if_pc  in  XLEN  current fetch PC
pred_hit  out  1  valid entry with matching tag exists for if_pc
pred_taken  out  1  prediction is taken
pred_target  out  XLEN  predicted next PC
pred_state  out  2  counter state of the hit entry, or 01 on a miss
upd_en  in  1  resolved control-flow instruction from EX
upd_pc  in  XLEN  PC of the resolved instruction
upd_taken  in  1  actual outcome
upd_target  in  XLEN  actual target
upd_is_jump  in  1  JAL/JALR (unconditional)
upd_mispredict  in  1  EX detected a misprediction; statistics only
flush_all  in  1  invalidate every entry
hit_count  out  PERF_COUNTER_WIDTH  number of qualified lookup hits
mispredict_count  out  PERF_COUNTER_WIDTH  number of reported mispredicts

Behaviour:
- Lookup is combinational from registered storage: zero-cycle latency from if_pc to the pred_* outputs. PC bits [1:0] are ignored.
- On a hit:
  - pred_taken = state[1].
  - pred_target = stored target when pred_taken, else if_pc+4 (mod 2^XLEN).
  - pred_state = stored state.
- On a miss: pred_hit=0, pred_taken=0, pred_target=if_pc+4, pred_state=01.
- Update, registered on the rising edge when upd_en=1. Index and tag are taken from upd_pc.
  - Tag hit, upd_is_jump=1: state <= 11 and target <= upd_target.
  - Tag hit, taken: state increments, saturating at 11; target <= upd_target.
  - Tag hit, not taken: state decrements, saturating at 00; target unchanged.
  - Miss and upd_taken=1: allocate or overwrite the slot. Set valid=1 and write tag and target. State <= 11 if upd_is_jump, else 10.
  - Miss and upd_taken=0: no change; no allocation on not-taken.
- Read-during-write: a lookup to the slot being updated in the same cycle returns the old contents. The new contents are visible the next cycle.
- flush_all: clears every valid bit on the next edge. Counters and targets are left as-is but are unreachable. If flush_all and upd_en are asserted in the same cycle, the flush wins and no allocation occurs.
- hit_count increments when if_valid && pred_hit.
- mispredict_count increments when upd_en && upd_mispredict.
- Both statistics counters saturate at all-ones and are not cleared by flush_all.
- Reset (asynchronous, any time, including mid-update):
  - All valid bits go to 0 and all states go to 01; tags and targets are don't-care.
  - hit_count and mispredict_count go to 0.
  - Consequently pred_hit=0, pred_taken=0, pred_target=if_pc+4, pred_state=01 while reset is held and afterwards until the first allocation.
  - An update in flight when reset asserts is discarded.
- Aliasing: two PCs with equal index but different tags evict each other. No associativity.

Test Plan:
- Reset then lookup: if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104, pred_state=01; both counters 0.
- Allocate a branch: upd_pc=0x100, taken, target 0x40 -> next cycle lookup 0x100 gives hit=1, taken=1, target=0x40, state=10. Same-cycle lookup still misses.
- Saturation: 3 more taken updates -> state 11; then 4 not-taken updates -> states 10, 01, 00, 00. From 01 onward taken=0 and target=0x104.
- Jump and alias: JAL at 0x200, target 0x80 -> state 11. Then taken update at 0x200+(64*4)=0x300 -> 0x300 hits and 0x200 misses.
- Flush vs update: flush_all and upd_en in the same cycle for 0x100 -> 0x100 misses afterwards; hit_count retains its prior value.
- Stats and async reset: 5 hit cycles with if_valid=1 plus 2 without -> hit_count=5. 3 mispredicts -> mispredict_count=3. Assert rst mid-cycle between edges -> outputs clear immediately.
